// File: rtl/aes_rcon_sequencer.sv
// Sequences AES key-expansion word steps (forward or inverse) and drives the
// masked rcon generator's init/update/mask/direction/key-size controls.
module aes_rcon_sequencer #(
   parameter int SUPPORT_256 = 1,
   parameter int IDX_W       = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic             mode_256,
   input  logic             inverse,
   output logic             step_valid,
   input  logic             step_ready,
   output logic [IDX_W-1:0] word_idx,
   output logic             use_rcon,
   output logic             use_sbox,
   output logic             last_word,
   output logic             rcon_init,
   output logic             rcon_update,
   output logic             rcon_mask,
   output logic             rcon_inverse,
   output logic             rcon_mode_256,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic             mode_q, inv_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] nk, top_idx, first_idx, end_idx;
   logic             start_hs, step_hs, is_rcon, is_sbox, is_last;

   assign nk        = mode_q ? IDX_W'(8) : IDX_W'(4);
   assign top_idx   = mode_q ? IDX_W'(59) : IDX_W'(43);
   assign first_idx = inv_q ? top_idx : nk;
   assign end_idx   = inv_q ? nk : top_idx;

   // Nk is a power of two, so "i mod Nk == 0" is a check of the low index bits.
   assign is_rcon = mode_q ? (idx_q[2:0] == 3'd0) : (idx_q[1:0] == 2'd0);
   assign is_sbox = mode_q & (idx_q[2:0] == 3'd4);
   assign is_last = (idx_q == end_idx);

   assign start_hs = (state == IDLE) & start_valid;
   assign step_hs  = (state == RUN) & step_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_valid) state_nxt = INIT;
         INIT:    state_nxt = RUN;
         RUN:     if (step_ready && is_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Direction and key size persist after the run so the generator sees
   // stable controls until the next start is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= 1'b0;
         inv_q  <= 1'b0;
      end else if (start_hs) begin
         mode_q <= (SUPPORT_256 != 0) && mode_256;
         inv_q  <= inverse;
      end
   end

   // The index is not moved past the end word, so it stays inside the
   // schedule's range after the final handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (state == INIT) begin
         idx_q <= first_idx;
      end else if (step_hs && !is_last) begin
         idx_q <= inv_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
      end
   end

   always_comb begin
      start_ready = (state == IDLE);
      step_valid  = (state == RUN);
      rcon_init   = (state == INIT);
      done        = (state == DONE);
      use_rcon    = (state == RUN) & is_rcon;
      use_sbox    = (state == RUN) & is_sbox;
      last_word   = (state == RUN) & is_last;
      rcon_mask   = (state == RUN) & is_rcon;
      rcon_update = step_hs & is_rcon;
   end

   assign word_idx      = idx_q;
   assign rcon_inverse  = inv_q;
   assign rcon_mode_256 = mode_q;

endmodule

// File: tb/tb_aes_rcon_sequencer.sv
// Bench for aes_rcon_sequencer: table of runs against a schedule/GF(2^8) rcon
// model, random backpressure, held start, mid-run reset, and a SUPPORT_256=0 copy.
module tb_aes_rcon_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_valid, mode_256, inverse, step_ready;
   logic       start_ready, step_valid, use_rcon, use_sbox, last_word;
   logic       rcon_init, rcon_update, rcon_mask, rcon_inverse, rcon_mode_256, done;
   logic [5:0] word_idx;

   logic       d0_start_ready, d0_step_valid, d0_use_rcon, d0_use_sbox, d0_last_word;
   logic       d0_rcon_init, d0_rcon_update, d0_rcon_mask, d0_rcon_inverse, d0_rcon_mode_256, d0_done;
   logic [5:0] d0_word_idx;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aes_rcon_sequencer #(.SUPPORT_256(1), .IDX_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .mode_256(mode_256), .inverse(inverse), .step_valid(step_valid), .step_ready(step_ready),
      .word_idx(word_idx), .use_rcon(use_rcon), .use_sbox(use_sbox), .last_word(last_word),
      .rcon_init(rcon_init), .rcon_update(rcon_update), .rcon_mask(rcon_mask),
      .rcon_inverse(rcon_inverse), .rcon_mode_256(rcon_mode_256), .done(done)
   );

   aes_rcon_sequencer #(.SUPPORT_256(0), .IDX_W(6)) dut0 (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(d0_start_ready),
      .mode_256(mode_256), .inverse(inverse), .step_valid(d0_step_valid), .step_ready(step_ready),
      .word_idx(d0_word_idx), .use_rcon(d0_use_rcon), .use_sbox(d0_use_sbox), .last_word(d0_last_word),
      .rcon_init(d0_rcon_init), .rcon_update(d0_rcon_update), .rcon_mask(d0_rcon_mask),
      .rcon_inverse(d0_rcon_inverse), .rcon_mode_256(d0_rcon_mode_256), .done(d0_done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] xi(input logic [7:0] b);
      return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
   endfunction

   // rcon for round j is x^(j-1) in GF(2^8)
   function automatic logic [7:0] rcon_of(input int j);
      logic [7:0] r = 8'h01;
      for (int i = 1; i < j; i++) r = xt(r);
      return r;
   endfunction

   typedef struct {
      bit         m;
      bit         inv;
      int         bp;
      bit         hold;
      int         steps;
      int         upd;
      int         sbox;
      logic [7:0] first_rc;
      logic [7:0] last_rc;
   } vec_t;

   vec_t vt[6];

   task automatic run_case(input bit m, input bit inv, input int bp, input bit hold,
                           output int steps, output int upd, output int sbox,
                           output logic [7:0] first_rc, output logic [7:0] last_rc,
                           output int d0_hs);
      int         q[$];
      int         nk, tot, k, cyc, idx;
      bit         er, es, el, fin, seen_rc;
      logic [7:0] gen;
      steps = 0; upd = 0; sbox = 0; first_rc = 8'h00; last_rc = 8'h00; d0_hs = 0;
      nk  = m ? 8 : 4;
      tot = m ? 60 : 44;
      for (int i = nk; i < tot; i++) begin
         if (inv) q.push_front(i);
         else     q.push_back(i);
      end
      @(negedge clk); #1;
      chk("idle_start_ready", start_ready, 1);
      start_valid = 1'b1; mode_256 = m; inverse = inv; step_ready = 1'b0;
      @(negedge clk); #1;
      if (!hold) start_valid = 1'b0;
      chk("init_pulse", rcon_init, 1);
      chk("init_no_step", step_valid, 0);
      chk("init_start_ready", start_ready, 0);
      chk("init_mode", rcon_mode_256, m);
      chk("init_inverse", rcon_inverse, inv);
      chk("d0_mode_forced0", d0_rcon_mode_256, 0);
      gen = inv ? (m ? 8'h40 : 8'h36) : 8'h01;
      cyc = 1; k = 0; fin = 0; seen_rc = 0;
      for (int c = 0; c < 600 && !fin; c++) begin
         @(negedge clk);
         step_ready = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
         #1;
         cyc++;
         if (d0_step_valid && step_ready) d0_hs++;
         if (d0_use_sbox) chk("d0_no_sbox", d0_use_sbox, 0);
         if (k < q.size()) begin
            idx = q[k];
            er  = (idx % nk) == 0;
            es  = m && ((idx % 8) == 4);
            el  = (k == q.size() - 1);
            chk("step_valid", step_valid, 1);
            chk("word_idx", word_idx, idx);
            chk("use_rcon", use_rcon, er);
            chk("use_sbox", use_sbox, es);
            chk("last_word", last_word, el);
            chk("rcon_mask", rcon_mask, er);
            chk("rcon_update", rcon_update, er && step_ready);
            chk("run_no_init", rcon_init, 0);
            chk("run_start_ready", start_ready, 0);
            chk("run_no_done", done, 0);
            if (er) begin
               chk("gen_rcon", gen, rcon_of(idx / nk));
               if (!seen_rc) first_rc = gen;
               seen_rc = 1;
               last_rc = gen;
            end
            if (step_valid && step_ready) begin
               steps++;
               if (use_sbox) sbox++;
            end
            if (rcon_update) begin
               upd++;
               gen = inv ? xi(gen) : xt(gen);
            end
            if (step_ready) k++;
         end else begin
            chk("done_pulse", done, 1);
            chk("done_no_step", step_valid, 0);
            if (bp == 0) chk("start_to_done", cyc, 2 + q.size());
            start_valid = 1'b0;
            fin = 1;
         end
      end
      if (!fin) chk("run_timeout", 0, 1);
      @(negedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("back_idle", start_ready, 1);
      chk("mode_kept", rcon_mode_256, m);
      chk("inverse_kept", rcon_inverse, inv);
   endtask

   initial begin
      int         steps, upd, sbox, d0_hs;
      logic [7:0] frc, lrc;
      bit         hit;
      vt[0] = '{0, 0, 0,  0, 40, 10, 0, 8'h01, 8'h36};
      vt[1] = '{0, 1, 0,  0, 40, 10, 0, 8'h36, 8'h01};
      vt[2] = '{1, 0, 0,  0, 52,  7, 6, 8'h01, 8'h40};
      vt[3] = '{1, 1, 0,  0, 52,  7, 6, 8'h40, 8'h01};
      vt[4] = '{0, 0, 50, 1, 40, 10, 0, 8'h01, 8'h36};
      vt[5] = '{1, 1, 50, 0, 52,  7, 6, 8'h40, 8'h01};

      rst_n = 1'b0; start_valid = 1'b0; mode_256 = 1'b0; inverse = 1'b0; step_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_start_ready", start_ready, 1);
      chk("rst_step_valid", step_valid, 0);
      chk("rst_word_idx", word_idx, 0);
      chk("rst_use_rcon", use_rcon, 0);
      chk("rst_rcon_init", rcon_init, 0);
      chk("rst_mode", rcon_mode_256, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         run_case(vt[i].m, vt[i].inv, vt[i].bp, vt[i].hold, steps, upd, sbox, frc, lrc, d0_hs);
         chk($sformatf("v%0d_steps", i), steps, vt[i].steps);
         chk($sformatf("v%0d_updates", i), upd, vt[i].upd);
         chk($sformatf("v%0d_sbox", i), sbox, vt[i].sbox);
         chk($sformatf("v%0d_first_rcon", i), frc, vt[i].first_rc);
         chk($sformatf("v%0d_last_rcon", i), lrc, vt[i].last_rc);
         chk($sformatf("v%0d_d0_steps", i), d0_hs, 40);
      end

      // Reset in the middle of a forward AES-128 run at word 20.
      @(negedge clk);
      start_valid = 1'b1; mode_256 = 1'b0; inverse = 1'b0; step_ready = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      hit = 0;
      for (int c = 0; c < 100 && !hit; c++) begin
         @(negedge clk); #1;
         if (step_valid && word_idx == 6'd20) hit = 1;
      end
      chk("reach_idx20", hit, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_step_valid", step_valid, 0);
      chk("arst_word_idx", word_idx, 0);
      chk("arst_use_rcon", use_rcon, 0);
      chk("arst_rcon_mask", rcon_mask, 0);
      chk("arst_rcon_update", rcon_update, 0);
      chk("arst_start_ready", start_ready, 1);
      chk("arst_done", done, 0);
      chk("arst_d0_start_ready", d0_start_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_case(0, 0, 0, 0, steps, upd, sbox, frc, lrc, d0_hs);
      chk("post_rst_steps", steps, 40);
      chk("post_rst_updates", upd, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/aes_rcon_sequencer.md
Name: aes_rcon_sequencer

Overview:
Control-side driver for the masked round-constant generator used by the 32-bit AES key schedule. It sequences key-expansion word steps and drives the generator's sync init, update, mask_rcon, inverse and mode_256 controls. Runs forward (encryption key expansion) or inverse (unrolling from the last round key). It also tags each word step so the key datapath knows when to apply RotWord/SubWord/rcon or SubWord only.

Parameters:
SUPPORT_256, 1, when 0 mode_256 is ignored (treated as 0) and only AES-128 sequencing exists.
IDX_W, 6, width of word_idx; must be ≥6.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
start_valid  in  1  request to start a key-schedule run.
start_ready  out  1  high only in IDLE.
mode_256  in  1  key size select, sampled on the start handshake.
inverse  in  1  direction select, sampled on the start handshake.
step_valid  out  1  a word step is presented to the key datapath.
step_ready  in  1  datapath accepts the current step.
word_idx  out  IDX_W  expansion word index i of the current step.
use_rcon  out  1  current step applies RotWord+SubWord+rcon.
use_sbox  out  1  current step applies SubWord only (AES-256, i mod 8 == 4).
last_word  out  1  current step is the final step of the run.
rcon_init  out  1  synchronous active-high init to the rcon generator.
rcon_update  out  1  rcon generator advance strobe.
rcon_mask  out  1  rcon generator output gate (high = pass rcon).
rcon_inverse  out  1  registered direction to the generator.
rcon_mode_256  out  1  registered key size to the generator.
done  out  1  one-cycle pulse after the last step is accepted.

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0 except start_ready=1. word_idx=0.
- Nk=4/Nr=10 (128) or Nk=8/Nr=14 (256). Forward index range: Nk .. 4*(Nr+1)-1, which is 4..43 or 8..59.
- States: IDLE, INIT, RUN, DONE.
- IDLE: on start_valid&start_ready:
  - latch mode (forced 0 if !SUPPORT_256) and inverse into rcon_mode_256/rcon_inverse.
  - go to INIT.
- INIT: exactly one cycle, rcon_init=1, step_valid=0.
  - word_idx is loaded to Nk (forward) or 4*(Nr+1)-1 (inverse: 43 or 59).
  - Next state RUN.
- RUN: step_valid=1.
  - use_rcon = (word_idx mod Nk == 0).
  - use_sbox = rcon_mode_256 & (word_idx mod 8 == 4).
  - rcon_mask = use_rcon.
  - last_word = word_idx == end index (43/59 forward, Nk inverse).
- Handshake (step_valid&step_ready):
  - word_idx increments (forward) or decrements (inverse).
  - rcon_update = use_rcon in that same cycle, so the generator advances at that edge; rcon_update is never asserted otherwise.
- Stall: step_ready low holds all outputs and state stable; no update.
- On the handshake of last_word: go to DONE. DONE asserts done=1 for one cycle, then IDLE.
- rcon_inverse/rcon_mode_256 stay stable from INIT until the next start is accepted; they are not cleared in IDLE.
- Counts per run:
  - 128: 40 steps, 10 rcon updates.
  - 256: 52 steps, 7 rcon updates, 6 use_sbox steps.
- Inverse first rcon use must see the generator's init value: 0x36 (128) or 0x40 (256). This holds because INIT precedes RUN.
- start_valid in any state other than IDLE is ignored (start_ready=0).
- Async reset mid-run aborts immediately; no done pulse. The next run must re-INIT the generator.
- Minimum latency start→first step_valid: 2 cycles. Start→done with step_ready tied high: 2+steps cycles.

Test Plan:
- Forward 128, step_ready=1:
  - start→INIT pulse, then word_idx 4..43 over 40 cycles; use_rcon at 4,8,…,40.
  - rcon_update count 10; generator rcon sequence 01,02,04,…,80,1b,36; done at cycle 42.
- Inverse 128:
  - word_idx 43 down to 4; first use_rcon at 40 with generator rcon 0x36.
  - rcon sequence 36,1b,80,…,01; last_word at idx 4.
- Forward/inverse 256:
  - 52 steps; use_rcon at 8,16,…,56 (7), use_sbox at 12,20,…,52 (6).
  - inverse first rcon 0x40, last 0x01.
- Random step_ready backpressure (50%):
  - outputs stable while stalled.
  - total handshakes 40/52.
  - rcon_update only on use_rcon handshakes.
- Control corner cases:
  - start_valid held during run → ignored.
  - rst_n low at idx 20 → all outputs 0 asynchronously, start_ready=1.
  - new start after reset → rcon_init pulse and idx restarts at 4.
- SUPPORT_256=0 with mode_256=1 → AES-128 sequence, rcon_mode_256=0.
